alu_mul_div_seq: RTL

Sequencer that sits directly upstream of the multi-cycle multiply/divide unit (`alu_mul_div`) and owns its whole transaction. It accepts one operation at a time from execute over a valid/ready handshake and registers the operands and opcode. It then pulses the unit's submit, holds every unit input stable until the unit's busy drops, and captures the result. The result is presented downstream with valid/ready and a tag. Divide/modulo by zero and reserved opcodes bypass the unit.

---
 rtl/alu_mul_div_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mul_div_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_div_seq
//
// Transaction sequencer in front of the multi-cycle multiply/divide unit.
// It accepts one operation at a time from execute and registers its operands,
// opcode and tag. It then pulses the unit's submit for one cycle and holds every
// unit input stable until the unit reports not-busy. Finally it captures the
// unit's result and presents it downstream with valid/ready and the original
// tag. Divide/modulo by zero and the reserved opcode never reach the unit; their
// result is produced locally in the cycle after accept.
//
// Parameters
//   RW            datapath width (must match the mul/div unit)
//   TW            tag width
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid / o_req_ready request handshake (accept on valid & ready)
//   i_req_op                  00 mul, 01 div, 10 mod, 11 reserved
//   i_req_a, i_req_b          operands
//   i_req_tag                 tag returned with the result
//   o_res_valid / i_res_ready result handshake
//   o_res_d, o_res_tag        result data and its tag
//   o_res_dz                  result came from a div/mod by zero
//   i_flush                   abort the current operation
//   o_md_a, o_md_b            held operands to the unit
//   o_md_mul/div/mod          held one-hot mode to the unit
//   o_md_submit               one-cycle start pulse to the unit
//   o_md_flush                flush to the unit (same cycle as i_flush)
//   i_md_d                    unit result (combinational on its mode inputs)
//   i_md_busy                 unit busy (submit OR computing)
// -----------------------------------------------------------------------------
module alu_mul_div_seq #(
    parameter int RW = 16,
    parameter int TW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [1:0]    i_req_op,
    input  logic [RW-1:0] i_req_a,
    input  logic [RW-1:0] i_req_b,
    input  logic [TW-1:0] i_req_tag,

    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [RW-1:0] o_res_d,
    output logic [TW-1:0] o_res_tag,
    output logic          o_res_dz,

    input  logic          i_flush,

    output logic [RW-1:0] o_md_a,
    output logic [RW-1:0] o_md_b,
    output logic          o_md_mul,
    output logic          o_md_div,
    output logic          o_md_mod,
    output logic          o_md_submit,
    output logic          o_md_flush,
    input  logic [RW-1:0] i_md_d,
    input  logic          i_md_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t        r_state;
    state_t        w_next_state;

    logic [RW-1:0] r_a;
    logic [RW-1:0] r_b;
    logic [1:0]    r_op;
    logic [TW-1:0] r_tag;
    logic [RW-1:0] r_res_d;
    logic          r_res_dz;

    logic          w_accept;
    logic          w_req_div_zero;
    logic          w_req_rsv;
    logic          w_req_bypass;
    logic          w_capture;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    // A flush cycle never accepts, so i_flush is folded into ready itself.
    assign o_req_ready    = (r_state == ST_IDLE) & ~i_flush;
    assign w_accept       = i_req_valid & o_req_ready;

    assign w_req_div_zero = ((i_req_op == OP_DIV) || (i_req_op == OP_MOD)) &&
                            (i_req_b == '0);
    assign w_req_rsv      = (i_req_op == OP_RSV);
    assign w_req_bypass   = w_req_div_zero | w_req_rsv;

    // The unit's result is only taken once busy has fallen in WAIT; a flush in
    // that same cycle wins and the result is discarded.
    assign w_capture      = (r_state == ST_WAIT) & ~i_md_busy & ~i_flush;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path assigned, so no latch is inferred for unlisted cases.
    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_next_state = w_req_bypass ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_next_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!i_md_busy) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Request and result registers
    // -------------------------------------------------------------------------
    // Operands, op and tag change only on accept, so the unit inputs and the
    // returned tag stay frozen through ISSUE, WAIT and DONE.
    // r_op resets to the reserved code so that all mode bits read 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_RSV;
            r_tag    <= '0;
            r_res_d  <= '0;
            r_res_dz <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_req_a;
            r_b      <= i_req_b;
            r_op     <= i_req_op;
            r_tag    <= i_req_tag;
            r_res_dz <= w_req_div_zero;
            // Bypass results are known at accept. Div by zero saturates to
            // all ones and mod by zero returns the dividend.
            if (w_req_div_zero) begin
                r_res_d <= (i_req_op == OP_DIV) ? '1 : i_req_a;
            end else if (w_req_rsv) begin
                r_res_d <= '0;
            end
        end else if (w_capture) begin
            r_res_d  <= i_md_d;
            r_res_dz <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_res_valid = (r_state == ST_DONE);
    assign o_res_d     = r_res_d;
    assign o_res_tag   = r_tag;
    assign o_res_dz    = r_res_dz;

    assign o_md_a      = r_a;
    assign o_md_b      = r_b;
    assign o_md_mul    = (r_op == OP_MUL);
    assign o_md_div    = (r_op == OP_DIV);
    assign o_md_mod    = (r_op == OP_MOD);

    // Submit is a pure function of ISSUE, which lasts exactly one cycle. A
    // flush in ISSUE reaches the unit at the same edge and takes priority there.
    assign o_md_submit = (r_state == ST_ISSUE);
    assign o_md_flush  = i_flush;

endmodule
